// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2-to-keypad controller for the Studio II core.
// Decodes PS/2 key events into one or two 10-key pads and stretches releases
// so polling software sees short taps. Latches the CPU key-select value and
// drives the per-pad EF flags.
module studio2_keypad #(
   parameter int unsigned KEYPADS     = 2,
   parameter logic [2:0]  IO_PORT     = 3'd2,
   parameter int unsigned HOLD_CYCLES = 358000,
   parameter bit          SINGLE_MAP  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [10:0]             ps2_key,
   input  logic                    io_out,
   input  logic [2:0]              io_n,
   input  logic [7:0]              io_dout,
   output logic [KEYPADS-1:0]      ef,
   output logic [3:0]              key_sel,
   output logic [KEYPADS-1:0]      any_down,
   output logic [KEYPADS*10-1:0]   key_state
);

   localparam int unsigned NKEYS = KEYPADS * 10;
   localparam int unsigned IDX_W = $clog2(NKEYS);
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [7:0] PAD0_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] PAD1_CODES [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                               8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   logic             old_tgl;
   logic             ev;
   logic             hit;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [NKEYS-1:0] down;
   logic [1:0]       age [NKEYS];
   logic [NKEYS-1:0] eff;
   logic [KEYPADS-1:0] ef_next;
   logic [15:0]      padv;
   logic             unused_dout_hi;

   assign unused_dout_hi = ^io_dout[7:4];

   // Track the event toggle; reset loads the live level so no event follows it.
   always_ff @(posedge clk) begin
      old_tgl <= ps2_key[10];
   end

   // Decode an incoming event to a flat key index (pad*10 + key).
   always_comb begin
      ev  = (ps2_key[10] != old_tgl) && !ps2_key[8];
      hit = 1'b0;
      idx = '0;
      for (int unsigned k = 0; k < 10; k++) begin
         if (ps2_key[7:0] == PAD0_CODES[k]) begin
            hit = 1'b1;
            idx = IDX_W'(k);
         end
         if (ps2_key[7:0] == PAD1_CODES[k]) begin
            if (KEYPADS > 1) begin
               hit = 1'b1;
               idx = IDX_W'(k + 10);
            end else if (SINGLE_MAP) begin
               hit = 1'b1;
               idx = IDX_W'(k);
            end
         end
      end
   end

   // Free-running prescaler with a one-cycle tick on wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_W'(HOLD_CYCLES - 1));

   // Per-key down/age state; an event on the same key overrides the tick decrement.
   always_ff @(posedge clk) begin
      if (reset) begin
         down <= '0;
         for (int unsigned i = 0; i < NKEYS; i++) begin
            age[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NKEYS; i++) begin
            if (tick && age[i] != '0) begin
               age[i] <= age[i] - 2'd1;
            end
            if (ev && hit && idx == IDX_W'(i)) begin
               if (ps2_key[9]) begin
                  down[i] <= 1'b1;
                  age[i]  <= 2'd0;
               end else begin
                  down[i] <= 1'b0;
                  age[i]  <= 2'd2;
               end
            end
         end
      end
   end

   // Effective key bits and per-pad selected key (selects 10-15 hit the zero padding).
   always_comb begin
      padv    = '0;
      ef_next = '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
         eff[i] = down[i] | (age[i] != '0);
      end
      for (int unsigned p = 0; p < KEYPADS; p++) begin
         padv       = {6'b0, eff[p*10 +: 10]};
         ef_next[p] = padv[key_sel];
      end
   end

   // Key-select latch written by OUT on the configured port.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_sel <= '0;
      end else if (io_out && io_n == IO_PORT) begin
         key_sel <= io_dout[3:0];
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ef        <= '0;
         any_down  <= '0;
         key_state <= '0;
      end else begin
         ef        <= ef_next;
         key_state <= eff;
         for (int unsigned p = 0; p < KEYPADS; p++) begin
            any_down[p] <= |eff[p*10 +: 10];
         end
      end
   end

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad: a two-pad instance plus single-pad
// instances with and without numeric-keypad mapping, all sharing stimulus.
module tb_studio2_keypad;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic        io_out;
   logic [2:0]  io_n;
   logic [7:0]  io_dout;

   logic [1:0]  ef_a;
   logic [3:0]  sel_a;
   logic [1:0]  any_a;
   logic [19:0] ks_a;
   logic [0:0]  ef_1, any_1, ef_0, any_0;
   logic [3:0]  sel_1, sel_0;
   logic [9:0]  ks_1, ks_0;

   int checks = 0;
   int errors = 0;
   int ec = 0;
   logic tgl;

   always #5 clk = ~clk;

   // Non-reset edges since reset release; matches the DUT prescaler phase.
   always @(posedge clk) begin
      if (reset) ec <= 0;
      else       ec <= ec + 1;
   end

   studio2_keypad #(.KEYPADS(2), .IO_PORT(3'd2), .HOLD_CYCLES(4), .SINGLE_MAP(1'b1)) u_dut (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
      .io_dout(io_dout), .ef(ef_a), .key_sel(sel_a), .any_down(any_a), .key_state(ks_a));

   studio2_keypad #(.KEYPADS(1), .IO_PORT(3'd2), .HOLD_CYCLES(4), .SINGLE_MAP(1'b1)) u_s1 (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
      .io_dout(io_dout), .ef(ef_1), .key_sel(sel_1), .any_down(any_1), .key_state(ks_1));

   studio2_keypad #(.KEYPADS(1), .IO_PORT(3'd2), .HOLD_CYCLES(4), .SINGLE_MAP(1'b0)) u_s0 (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
      .io_dout(io_dout), .ef(ef_0), .key_sel(sel_0), .any_down(any_0), .key_state(ks_0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      io_out = 1'b0;
   endtask

   task automatic key_ev(input logic pressed, input logic ext, input logic [7:0] code);
      tgl     = ~tgl;
      ps2_key = {tgl, pressed, ext, code};
   endtask

   task automatic out_set(input logic [2:0] n, input logic [7:0] d);
      io_out  = 1'b1;
      io_n    = n;
      io_dout = d;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int   m0, a, j;
      logic [1:0] prev_ef;
      logic drop;

      tgl     = 1'b1;
      ps2_key = {1'b1, 10'h000};
      io_out  = 1'b0;
      io_n    = 3'd0;
      io_dout = 8'h00;
      reset   = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (3) tick();
      check("rst_ef",  ef_a,  0);
      check("rst_ks",  ks_a,  0);
      check("rst_sel", sel_a, 0);
      check("rst_any", any_a, 0);

      // press code 16 together with select write 01
      key_ev(1'b1, 1'b0, 8'h16);
      out_set(3'd2, 8'h01);
      tick();
      check("sel_lat",   sel_a, 4'h1);
      check("press_lat", ks_a,  0);
      tick();
      check("press_ks",  ks_a,  20'h00002);
      check("press_any", any_a, 2'b01);
      check("press_ef",  ef_a,  2'b01);
      check("s1_ks16",   ks_1,  10'h002);

      key_ev(1'b1, 1'b0, 8'h16);
      repeat (2) tick();
      check("typematic", ks_a, 20'h00002);

      // release code 16: drop exactly 6 cycles after the first tick following release
      m0 = ec;
      a  = (7 - (m0 % 4)) % 4;
      if (a == 0) a = 4;
      key_ev(1'b0, 1'b0, 8'h16);
      j = 0;
      prev_ef = ef_a;
      while (ks_a[1] && j < 20) begin
         prev_ef = ef_a;
         tick();
         j++;
      end
      check("rel_time",    j,       a + 6);
      check("rel_ef_hold", prev_ef, 2'b01);
      check("rel_ef_drop", ef_a,    2'b00);
      check("rel_any",     any_a,   2'b00);

      // numpad 7A = pad 1 key 3
      key_ev(1'b1, 1'b0, 8'h7A);
      out_set(3'd2, 8'h03);
      repeat (2) tick();
      check("pad1_ef",  ef_a,  2'b10);
      check("pad1_ks",  ks_a,  20'h02000);
      check("pad1_any", any_a, 2'b10);
      check("s1_map",   ks_1,  10'h008);
      check("s0_nomap", ks_0,  10'h000);

      out_set(3'd2, 8'h0B);
      repeat (2) tick();
      check("sel_hi_ef", ef_a,  2'b00);
      check("sel_hi",    sel_a, 4'hB);
      out_set(3'd3, 8'h05);
      repeat (2) tick();
      check("port3_ign", sel_a, 4'hB);

      // reset mid-hold, with a toggle landing during reset
      reset = 1'b1;
      key_ev(1'b1, 1'b0, 8'h45);
      tick();
      check("rstm_ks",  ks_a,  0);
      check("rstm_sel", sel_a, 0);
      check("rstm_any", any_a, 0);
      check("rstm_ef",  ef_a,  0);
      check("rstm_s1",  ks_1,  0);
      reset = 1'b0;
      repeat (3) tick();
      check("no_spur", ks_a, 0);

      // code 75 = pad 1 key 8
      key_ev(1'b1, 1'b0, 8'h75);
      repeat (2) tick();
      check("k75_a",  ks_a, 20'h40000);
      check("k75_s1", ks_1, 10'h100);
      check("k75_s0", ks_0, 10'h000);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      key_ev(1'b1, 1'b1, 8'h75);
      repeat (2) tick();
      check("ext_a",  ks_a, 0);
      check("ext_s1", ks_1, 0);
      check("ext_s0", ks_0, 0);

      // key 5: press, release, re-press inside the stretch window
      key_ev(1'b1, 1'b0, 8'h2E);
      out_set(3'd2, 8'h05);
      repeat (2) tick();
      check("k5_press", ks_a, 20'h00020);
      key_ev(1'b0, 1'b0, 8'h2E);
      drop = 1'b0;
      repeat (3) begin
         tick();
         if (!ks_a[5]) drop = 1'b1;
      end
      key_ev(1'b1, 1'b0, 8'h2E);
      repeat (12) begin
         tick();
         if (!ks_a[5]) drop = 1'b1;
      end
      check("k5_nodrop", drop, 1'b0);
      check("k5_ef",     ef_a, 2'b01);

      key_ev(1'b0, 1'b0, 8'h2E);
      repeat (2) tick();
      check("k5_stretch", ks_a, 20'h00020);
      reset = 1'b1;
      tick();
      check("k5_rst_ks",  ks_a,  0);
      check("k5_rst_ef",  ef_a,  0);
      check("k5_rst_any", any_a, 0);
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
